fir_uart_top: RTL and testbench
===============================

Name: fir_uart_top

Overview:
- Top-level streaming filter, reachable over a serial line.
- A UART receiver assembles 16-bit signed samples from byte pairs sent by the host, high byte first.
- A 4-tap FIR filter processes each sample.
- Each filtered 16-bit result goes back to the host through a UART transmitter as two bytes, high byte first.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated; 434 by default.
- COEF0..COEF3, 1 each: signed 16-bit tap coefficients. COEF0 applies to the newest sample.
- SHIFT, 2: arithmetic right shift applied to the accumulator before output.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous active-low reset.
- from_computer  input  1  UART RX line; idle high.
- to_computer  output  1  UART TX line; idle high.

Behaviour:
- Reset is synchronous and active-low. While rst=0 at a rising edge:
  - to_computer=1.
  - RX and TX return to IDLE.
  - Byte-pair phase returns to "expect high byte".
  - Sample history x[0..3]=0.
- Frame format, both directions: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts CLKS_PER_BIT clocks.
- RX input: from_computer passes through a 2-flop synchronizer before any use.
- RX state machine:
  - IDLE -> START on a synchronized falling level (0).
  - START: wait CLKS_PER_BIT/2 clocks, then re-sample. If the line is 0, go to DATA; if 1, it was a glitch, go back to IDLE.
  - DATA: sample 8 bits, each CLKS_PER_BIT apart, at mid-bit; shift them in LSB first.
  - STOP: sample at mid-stop-bit. If 1, pulse byte_valid for 1 cycle; if 0 (framing error), discard the byte and do not change the pair phase. Return to IDLE.
- Byte pairing:
  - The first valid byte after reset, or after a completed pair, is the high byte; the next is the low byte.
  - Sample = {high, low}, signed two's complement.
  - No inter-byte timeout.
- FIR:
  - The cycle after the low byte is valid: x[3]<=x[2], x[2]<=x[1], x[1]<=x[0], x[0]<=sample.
  - Same cycle: acc = COEF0*sample + COEF1*x[0] + COEF2*x[1] + COEF3*x[2], computed on the pre-shift history, in 34-bit signed arithmetic.
  - Result y = acc >>> SHIFT, saturated to the range -32768..32767.
  - The result is registered and raises tx_req for 1 cycle.
- TX:
  - On tx_req, latch y. Send the high byte, then immediately the low byte, with no idle gap. Each byte is start + 8 data + stop.
  - Latency: the first start-bit level appears on to_computer 2 clocks after the RX mid-stop sample of the low byte.
  - If tx_req arrives while TX is busy, it is held in a one-deep pending register. A newer request overwrites an older pending one. Pending data is sent right after the current pair.
- RX and TX run fully independently (full duplex).
- Reset mid-frame aborts both directions immediately. to_computer goes high; a partial byte or pair is lost.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release -> to_computer stays 1 and no frames are emitted for 100 µs of idle line.
- Send bytes 0x01 then 0x25 at 8680 ns/bit (sample 0x0125=293) -> TX emits 0x00 then 0x49 (y=73). Start bit must begin 2 clocks after the RX stop-bit sample point. Each bit must be 434±1 clocks.
- Send sample 0x0125 a second time -> y=586>>>2=146, TX emits 0x00, 0x92. A third and fourth 0x0125 -> 0x00DB, then 0x0125.
- After reset, send 0xFF,0xFC (-4) -> y=-1, TX emits 0xFF, 0xFF. With COEF0=32767, SHIFT=0 and input 0x7FFF -> saturates to 0x7FFF.
- Framing and glitch:
  - A high byte with stop bit 0, then valid bytes 0x01, 0x25 -> the bad byte is ignored and output is 0x00, 0x49.
  - A 100 ns low glitch on the idle line -> no byte is received.
- Assert rst=0 mid-transmission -> to_computer=1 on the next edge. The next sample uses zero history: 0x0125 -> 0x0049.

Source files
------------

// File: rtl/fir_uart_top.sv
// rtl/fir_uart_top.sv - UART-attached 4-tap FIR: byte pairs in, filtered byte pairs out
module fir_uart_top #(
   parameter int                 CLK_FREQ = 50000000,
   parameter int                 BAUD     = 115200,
   parameter logic signed [15:0] COEF0    = 16'sd1,
   parameter logic signed [15:0] COEF1    = 16'sd1,
   parameter logic signed [15:0] COEF2    = 16'sd1,
   parameter logic signed [15:0] COEF3    = 16'sd1,
   parameter int                 SHIFT    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic from_computer,
   output logic to_computer
);

   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(CPB + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

   function automatic logic signed [33:0] ext16(input logic signed [15:0] v);
      return {{18{v[15]}}, v};
   endfunction

   logic          rx_s1, rx_s2;
   uart_state_t   rx_state, rx_state_d;
   logic [CW-1:0] rx_cnt, rx_cnt_d;
   logic [2:0]    rx_bit, rx_bit_d;
   logic [7:0]    rx_shift, rx_shift_d;
   logic          byte_valid, byte_valid_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_state   <= S_IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         byte_valid <= 1'b0;
      end else begin
         rx_s1      <= from_computer;
         rx_s2      <= rx_s1;
         rx_state   <= rx_state_d;
         rx_cnt     <= rx_cnt_d;
         rx_bit     <= rx_bit_d;
         rx_shift   <= rx_shift_d;
         byte_valid <= byte_valid_d;
      end
   end

   // START waits half a bit so every later sample lands mid-bit
   always_comb begin
      rx_state_d   = rx_state;
      rx_cnt_d     = rx_cnt + CW'(1);
      rx_bit_d     = rx_bit;
      rx_shift_d   = rx_shift;
      byte_valid_d = 1'b0;
      case (rx_state)
         S_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s2) rx_state_d = S_START;
         end
         S_START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2 ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2, rx_shift[7:1]};
               rx_bit_d   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_d     = '0;
               byte_valid_d = rx_s2;
               rx_state_d   = S_IDLE;
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // x[3] never feeds the sum, so only three history words are kept
   logic               phase_lo;
   logic [7:0]         hi_byte;
   logic signed [15:0] sample, x0, x1, x2, y_reg, y_sat;
   logic signed [33:0] acc, acc_sh;
   logic               tx_req;

   assign sample = {hi_byte, rx_shift};

   always_comb begin
      acc = ext16(COEF0) * ext16(sample) + ext16(COEF1) * ext16(x0)
          + ext16(COEF2) * ext16(x1) + ext16(COEF3) * ext16(x2);
      acc_sh = acc >>> SHIFT;
      if (acc_sh > 34'sd32767)        y_sat = 16'sh7fff;
      else if (acc_sh < -34'sd32768)  y_sat = 16'sh8000;
      else                            y_sat = acc_sh[15:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_lo <= 1'b0;
         hi_byte  <= '0;
         x0       <= '0;
         x1       <= '0;
         x2       <= '0;
         y_reg    <= '0;
         tx_req   <= 1'b0;
      end else begin
         tx_req <= 1'b0;
         if (byte_valid) begin
            if (!phase_lo) begin
               hi_byte  <= rx_shift;
               phase_lo <= 1'b1;
            end else begin
               phase_lo <= 1'b0;
               x2       <= x1;
               x1       <= x0;
               x0       <= sample;
               y_reg    <= y_sat;
               tx_req   <= 1'b1;
            end
         end
      end
   end

   uart_state_t   tx_state, tx_state_d;
   logic [CW-1:0] tx_cnt, tx_cnt_d;
   logic [2:0]    tx_bit, tx_bit_d;
   logic [15:0]   tx_word, tx_word_d, pend_data, pend_data_d;
   logic          tx_lo, tx_lo_d, pend_valid, pend_valid_d, txd, txd_d, take;
   logic [7:0]    cur_byte;

   assign cur_byte    = tx_lo ? tx_word[7:0] : tx_word[15:8];
   assign to_computer = txd;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state   <= S_IDLE;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_word    <= '0;
         tx_lo      <= 1'b0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         txd        <= 1'b1;
      end else begin
         tx_state   <= tx_state_d;
         tx_cnt     <= tx_cnt_d;
         tx_bit     <= tx_bit_d;
         tx_word    <= tx_word_d;
         tx_lo      <= tx_lo_d;
         pend_valid <= pend_valid_d;
         pend_data  <= pend_data_d;
         txd        <= txd_d;
      end
   end

   // A fresh request always beats an older pending one
   always_comb begin
      tx_state_d   = tx_state;
      tx_cnt_d     = tx_cnt + CW'(1);
      tx_bit_d     = tx_bit;
      tx_word_d    = tx_word;
      tx_lo_d      = tx_lo;
      txd_d        = txd;
      pend_valid_d = pend_valid | tx_req;
      pend_data_d  = tx_req ? y_reg : pend_data;
      take         = 1'b0;
      case (tx_state)
         S_IDLE: begin
            tx_cnt_d = '0;
            txd_d    = 1'b1;
            take     = tx_req | pend_valid;
         end
         S_START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               txd_d      = cur_byte[0];
               tx_state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit == 3'd7) begin
                  tx_state_d = S_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d = tx_bit + 3'd1;
                  txd_d    = cur_byte[tx_bit_d];
               end
            end
         end
         S_STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_d = '0;
               if (!tx_lo) begin
                  tx_lo_d    = 1'b1;
                  tx_state_d = S_START;
                  txd_d      = 1'b0;
               end else if (tx_req | pend_valid) begin
                  take = 1'b1;
               end else begin
                  tx_state_d = S_IDLE;
               end
            end
         end
         default: tx_state_d = S_IDLE;
      endcase
      if (take) begin
         tx_word_d    = tx_req ? y_reg : pend_data;
         pend_valid_d = 1'b0;
         tx_lo_d      = 1'b0;
         tx_cnt_d     = '0;
         tx_state_d   = S_START;
         txd_d        = 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_uart_top.sv
// tb/tb_fir_uart_top.sv - scoreboard bench for fir_uart_top
module tb_fir_uart_top;

   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 1562500;
   localparam int CPB      = CLK_FREQ / BAUD;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic from_main = 1'b1;
   logic from_sat  = 1'b1;
   logic to_main, to_sat;

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   fir_uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk(clk), .rst(rst), .from_computer(from_main), .to_computer(to_main)
   );

   fir_uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .COEF0(16'sd32767), .SHIFT(0)) dut_sat (
      .clk(clk), .rst(rst), .from_computer(from_sat), .to_computer(to_sat)
   );

   typedef struct {
      logic [7:0] data;
      bit         is_lo;
   } exp_t;

   exp_t   exp_q[$];
   int     checks = 0;
   int     errors = 0;
   bit     sel_sat = 1'b0;
   bit     mon_busy = 1'b0;
   int     lat_exp = -1;
   int     last_start = 0;
   longint hm0 = 0, hm1 = 0, hm2 = 0, hs0 = 0, hs1 = 0, hs2 = 0;

   function automatic logic [15:0] model(input longint s, input longint h0, input longint h1,
                                         input longint h2, input longint c0, input int sh);
      longint acc;
      acc = c0 * s + h0 + h1 + h2;
      acc = acc >>> sh;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      return acc[15:0];
   endfunction

   task automatic drive(input bit s, input logic v);
      if (s) from_sat = v;
      else   from_main = v;
   endtask

   task automatic send_byte(input bit s, input logic [7:0] d, input logic stop_bit,
                            input bit check_lat);
      @(negedge clk);
      drive(s, 1'b0);
      if (check_lat) lat_exp = cyc + 5 + CPB / 2 + 9 * CPB;
      repeat (CPB) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
         drive(s, d[j]);
         repeat (CPB) @(negedge clk);
      end
      drive(s, stop_bit);
      repeat (CPB) @(negedge clk);
      drive(s, 1'b1);
   endtask

   task automatic send_pair(input bit s, input logic [15:0] w, input bit check_lat);
      longint v;
      logic [15:0] y;
      v = longint'($signed(w));
      if (s) begin
         y = model(v, hs0, hs1, hs2, 32767, 0);
         hs2 = hs1; hs1 = hs0; hs0 = v;
      end else begin
         y = model(v, hm0, hm1, hm2, 1, 2);
         hm2 = hm1; hm1 = hm0; hm0 = v;
      end
      exp_q.push_back('{data: y[15:8], is_lo: 1'b0});
      exp_q.push_back('{data: y[7:0], is_lo: 1'b1});
      send_byte(s, w[15:8], 1'b1, 1'b0);
      send_byte(s, w[7:0], 1'b1, check_lat);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b1;
      hm0 = 0; hm1 = 0; hm2 = 0; hs0 = 0; hs1 = 0; hs2 = 0;
      exp_q.delete();
      lat_exp = -1;
   endtask

   // Frame decoder: pops one expectation per received byte
   initial begin : monitor
      logic prev, ln, stp, start_ok;
      logic [7:0] d;
      int t0, first_high, k;
      bit abort;
      exp_t e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         ln = sel_sat ? to_sat : to_main;
         if (rst && prev === 1'b1 && ln === 1'b0) begin
            t0 = cyc; mon_busy = 1'b1; abort = 1'b0; d = '0; stp = 1'b0;
            first_high = 0; start_ok = 1'b0;
            for (int n = 1; n <= CPB / 2 + 9 * CPB; n++) begin
               @(negedge clk);
               if (!rst) begin
                  abort = 1'b1;
                  break;
               end
               ln = sel_sat ? to_sat : to_main;
               if (first_high == 0 && ln === 1'b1) first_high = n;
               if (n == CPB / 2) start_ok = (ln === 1'b0);
               if (n > CPB / 2 && n < CPB / 2 + 9 * CPB && (n - CPB / 2) % CPB == 0) begin
                  k = (n - CPB / 2) / CPB - 1;
                  d[k] = ln;
               end
               if (n == CPB / 2 + 9 * CPB) stp = ln;
            end
            if (!abort) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_frame got=%02h required=none", d);
               end else begin
                  e = exp_q.pop_front();
                  if (d !== e.data || stp !== 1'b1 || start_ok !== 1'b1) begin
                     errors++;
                     $display("FAIL tx_byte got=%02h stop=%b start=%b required=%02h", d, stp, start_ok, e.data);
                  end
                  if (e.is_lo) begin
                     checks++;
                     if (t0 - last_start !== 10 * CPB) begin
                        errors++;
                        $display("FAIL pair_gap got=%0d required=%0d", t0 - last_start, 10 * CPB);
                     end
                  end else if (lat_exp >= 0) begin
                     checks++;
                     if (t0 !== lat_exp) begin
                        errors++;
                        $display("FAIL latency got_cycle=%0d required=%0d", t0, lat_exp);
                     end
                     lat_exp = -1;
                  end
               end
               if (d[0] === 1'b1) begin
                  checks++;
                  if (first_high < CPB - 1 || first_high > CPB + 1) begin
                     errors++;
                     $display("FAIL bit_width got=%0d required=%0d+-1", first_high, CPB);
                  end
               end
               last_start = t0;
            end
            mon_busy = 1'b0;
            prev = 1'b1;
         end else begin
            prev = ln;
         end
      end
   end

   task automatic test_reset();
      int lows;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (to_main !== 1'b1 || to_sat !== 1'b1) begin
         errors++;
         $display("FAIL reset_line got=%b%b required=11", to_main, to_sat);
      end
      do_reset(1);
      lows = 0;
      repeat (5000) begin
         @(negedge clk);
         if (to_main !== 1'b1 || to_sat !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL reset_idle low_cycles=%0d required=0", lows);
      end
   endtask

   task automatic test_basic();
      send_pair(1'b0, 16'h0125, 1'b1);
      send_pair(1'b0, 16'h0125, 1'b0);
      send_pair(1'b0, 16'h0125, 1'b0);
      send_pair(1'b0, 16'h0125, 1'b0);
      wait_drain(60 * CPB);
   endtask

   task automatic test_negative();
      do_reset(5);
      send_pair(1'b0, 16'hFFFC, 1'b0);
      wait_drain(60 * CPB);
   endtask

   task automatic test_saturation();
      sel_sat = 1'b1;
      send_pair(1'b1, 16'h7FFF, 1'b0);
      wait_drain(60 * CPB);
      sel_sat = 1'b0;
   endtask

   task automatic test_framing();
      do_reset(5);
      send_byte(1'b0, 8'hA5, 1'b0, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      send_pair(1'b0, 16'h0125, 1'b0);
      wait_drain(60 * CPB);
   endtask

   task automatic test_glitch();
      @(negedge clk);
      from_main = 1'b0;
      repeat (5) @(negedge clk);
      from_main = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checks++;
      if (mon_busy || exp_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_quiet busy=%b required=0", mon_busy);
      end
      send_pair(1'b0, 16'h0125, 1'b0);
      wait_drain(60 * CPB);
   endtask

   task automatic test_reset_mid_tx();
      int n;
      send_pair(1'b0, 16'h0125, 1'b0);
      n = 0;
      while (!mon_busy && n < 40 * CPB) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!mon_busy) begin
         errors++;
         $display("FAIL midtx_start busy=0 required=1");
      end
      repeat (3 * CPB) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (to_main !== 1'b1) begin
         errors++;
         $display("FAIL midtx_reset_line got=%b required=1", to_main);
      end
      do_reset(3);
      repeat (2 * CPB) @(negedge clk);
      send_pair(1'b0, 16'h0125, 1'b0);
      wait_drain(60 * CPB);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_saturation();
      test_framing();
      test_glitch();
      test_reset_mid_tx();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
